// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch with prefetch FIFO, redirect/flush; optional IF_ALIGN_CHECK_EN
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_o,
  output logic        ce_o,
  input  logic [31:0] inst_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic        adel_o,
  output logic [31:0] badaddr_o
`endif
);

  logic [31:0]        pc_q;
  logic               ce_q;
  logic [31:0]        fifo_pc   [FIFO_DEPTH];
  logic [31:0]        fifo_inst [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  logic               full;
  logic               pop;
  logic               fire;
  logic               redirect;
  logic [31:0]        redirect_target;
  logic [31:0]        aligned_target;
  logic               adel_q;
  logic [31:0]        badaddr_q;

  assign full            = (count == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign id_valid_o      = (count != '0);
  assign pop             = id_valid_o & id_ready_i;
  assign redirect        = flush_i | branch_flag_i;
  assign redirect_target = flush_i ? new_pc_i : branch_target_i;
  assign aligned_target  = redirect_target & 32'hFFFF_FFFC;
  assign fire            = ce_q & ~redirect & (~full | pop);

  assign pc_o      = pc_q;
  assign ce_o      = ce_q;
  assign id_pc_o   = id_valid_o ? fifo_pc[rd_ptr]   : 32'h0;
  assign id_inst_o = id_valid_o ? fifo_inst[rd_ptr] : 32'h0;

`ifdef IF_ALIGN_CHECK_EN
  assign adel_o    = adel_q;
  assign badaddr_o = badaddr_q;

  // PC, chip enable and sticky misaligned-redirect fault; only an aligned flush clears the fault
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      ce_q      <= 1'b0;
      adel_q    <= 1'b0;
      badaddr_q <= 32'h0;
    end else if (redirect) begin
      pc_q <= aligned_target;
      if (redirect_target[1:0] != 2'b00) begin
        adel_q    <= 1'b1;
        badaddr_q <= redirect_target;
        ce_q      <= 1'b0;
      end else if (flush_i) begin
        adel_q <= 1'b0;
        ce_q   <= 1'b1;
      end else begin
        ce_q <= ~adel_q;
      end
    end else begin
      if (fire) pc_q <= pc_q + 32'd4;
      ce_q <= ~adel_q;
    end
  end
`else
  assign adel_q    = 1'b0;
  assign badaddr_q = 32'h0;

  // PC and chip enable; redirect targets are forced onto a word boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      ce_q <= 1'b0;
    end else if (redirect) begin
      pc_q <= aligned_target;
      ce_q <= 1'b1;
    end else begin
      if (fire) pc_q <= pc_q + 32'd4;
      ce_q <= 1'b1;
    end
  end
`endif

  // FIFO pointers and occupancy; a redirect drops everything including a same-cycle pop
  always_ff @(posedge clk) begin
    if (!rst || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({fire, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: capture the fetched {pc,inst} pair; contents are qualified by count
  always_ff @(posedge clk) begin
    if (rst && fire) begin
      fifo_pc[wr_ptr]   <= pc_q;
      fifo_inst[wr_ptr] <= inst_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with queue model and directed vectors
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_o;
  logic        ce_o;
  logic [31:0] inst_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
`ifdef IF_ALIGN_CHECK_EN
  logic        adel_o;
  logic [31:0] badaddr_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign inst_i = rom(pc_o);

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .pc_o            (pc_o),
    .ce_o            (ce_o),
    .inst_i          (inst_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .id_valid_o      (id_valid_o),
    .id_ready_i      (id_ready_i),
    .id_pc_o         (id_pc_o),
    .id_inst_o       (id_inst_o)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .adel_o          (adel_o),
    .badaddr_o       (badaddr_o)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {pc,inst} words plus the fetch PC
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_adel;
  logic [31:0] m_bad;
  bit          m_init = 0;

  always @(posedge clk) begin
    logic        m_pop;
    logic        m_full;
    logic [31:0] t;
    if (!rst) begin
      m_init = 1;
      m_pc   = 32'h0;
      m_ce   = 1'b0;
      m_adel = 1'b0;
      m_bad  = 32'h0;
      mq.delete();
    end else if (m_init) begin
      m_pop  = (mq.size() != 0) && id_ready_i;
      m_full = (mq.size() == 4);
      if (flush_i || branch_flag_i) begin
        t = flush_i ? new_pc_i : branch_target_i;
        mq.delete();
        m_pc = {t[31:2], 2'b00};
`ifdef IF_ALIGN_CHECK_EN
        if (t % 4 != 0) begin
          m_adel = 1'b1;
          m_bad  = t;
        end else if (flush_i) begin
          m_adel = 1'b0;
        end
`endif
        m_ce = !m_adel;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_ce && (!m_full || m_pop)) begin
          mq.push_back({m_pc, rom(m_pc)});
          m_pc = m_pc + 32'd4;
        end
        m_ce = !m_adel;
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen
  always @(negedge clk) begin
    if (m_init) begin
      check("pc_o", pc_o, m_pc);
      check("ce_o", {31'b0, ce_o}, {31'b0, m_ce});
      check("id_valid_o", {31'b0, id_valid_o}, {31'b0, mq.size() != 0});
      check("id_pc_o", id_pc_o, (mq.size() != 0) ? mq[0][63:32] : 32'h0);
      check("id_inst_o", id_inst_o, (mq.size() != 0) ? mq[0][31:0] : 32'h0);
`ifdef IF_ALIGN_CHECK_EN
      check("adel_o", {31'b0, adel_o}, {31'b0, m_adel});
      check("badaddr_o", badaddr_o, m_bad);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b0;
    id_ready_i = rdy;
    branch_flag_i = 1'b0;
    flush_i = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  logic [7:0] rdy_pat;

  initial begin
    rst = 1'b0;
    id_ready_i = 1'b1;
    branch_flag_i = 1'b0;
    branch_target_i = 32'h0;
    flush_i = 1'b0;
    new_pc_i = 32'h0;

    // 1: streaming after reset
    do_reset(1'b1);
    check("t1_reset_ce", {31'b0, ce_o}, 32'h0);
    check("t1_reset_valid", {31'b0, id_valid_o}, 32'h0);
    check("t1_reset_pc", pc_o, 32'h0);
    tick(1);
    check("t1_ce_after_release", {31'b0, ce_o}, 32'h1);
    check("t1_pc0", pc_o, 32'h0);
    tick(1);
    check("t1_pc4", pc_o, 32'h4);
    check("t1_head_pc", id_pc_o, 32'h0);
    check("t1_head_inst", id_inst_o, 32'h0000_FFFF);
    tick(1);
    check("t1_head_pc4", id_pc_o, 32'h4);
    check("t1_head_inst4", id_inst_o, 32'h0004_FFFB);
    tick(4);

    // reset in mid-handshake loses contents
    rst = 1'b0;
    tick(1);
    check("rst_mid_valid", {31'b0, id_valid_o}, 32'h0);
    check("rst_mid_pc", id_pc_o, 32'h0);

    // 2: backpressure fills the FIFO then drains one per cycle
    do_reset(1'b0);
    tick(6);
    check("t2_pc_hold", pc_o, 32'h10);
    check("t2_head_pc", id_pc_o, 32'h0);
    check("t2_ce", {31'b0, ce_o}, 32'h1);
    id_ready_i = 1'b1;
    tick(1);
    check("t2_pop1_head", id_pc_o, 32'h4);
    check("t2_pop1_pc", pc_o, 32'h14);
    tick(3);
    check("t2_pop4_head", id_pc_o, 32'h10);
    rdy_pat = 8'b1011_0010;
    for (int i = 0; i < 16; i++) begin
      id_ready_i = rdy_pat[i % 8];
      tick(1);
    end

    // 3: branch out of a full FIFO
    do_reset(1'b0);
    tick(6);
    branch_flag_i = 1'b1;
    branch_target_i = 32'h100;
    id_ready_i = 1'b1;
    tick(1);
    check("t3_valid_cleared", {31'b0, id_valid_o}, 32'h0);
    check("t3_pc_target", pc_o, 32'h100);
    branch_flag_i = 1'b0;
    tick(1);
    check("t3_head_target", id_pc_o, 32'h100);
    tick(3);

    // 4: flush wins over a simultaneous branch
    flush_i = 1'b1;
    new_pc_i = 32'h180;
    branch_flag_i = 1'b1;
    branch_target_i = 32'h100;
    tick(1);
    check("t4_pc_flush", pc_o, 32'h180);
    flush_i = 1'b0;
    branch_flag_i = 1'b0;
    tick(1);
    check("t4_head_flush", id_pc_o, 32'h180);
    tick(2);

    // 5: PC wraps at the top of the address space
    flush_i = 1'b1;
    new_pc_i = 32'hFFFF_FFFC;
    tick(1);
    flush_i = 1'b0;
    check("t5_pc_top", pc_o, 32'hFFFF_FFFC);
    tick(1);
    check("t5_pc_wrap", pc_o, 32'h0);
    check("t5_head_top", id_pc_o, 32'hFFFF_FFFC);
    check("t5_inst_top", id_inst_o, 32'hFFFC_0003);
    tick(1);
    check("t5_head_zero", id_pc_o, 32'h0);
    tick(2);

    // 6: misaligned redirect target
    id_ready_i = 1'b0;
    tick(2);
    branch_flag_i = 1'b1;
    branch_target_i = 32'h102;
    tick(1);
    branch_flag_i = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    check("t6_adel", {31'b0, adel_o}, 32'h1);
    check("t6_badaddr", badaddr_o, 32'h102);
    check("t6_ce_off", {31'b0, ce_o}, 32'h0);
    tick(3);
    check("t6_still_off", {31'b0, ce_o}, 32'h0);
    flush_i = 1'b1;
    new_pc_i = 32'h380;
    id_ready_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    check("t6_adel_clr", {31'b0, adel_o}, 32'h0);
    check("t6_pc_resume", pc_o, 32'h380);
    tick(1);
    check("t6_head_resume", id_pc_o, 32'h380);
`else
    check("t6_pc_aligned", pc_o, 32'h100);
    id_ready_i = 1'b1;
    tick(1);
    check("t6_head_aligned", id_pc_o, 32'h100);
`endif
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
